mem_access_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the shared CU/data-memory interface.
- Requester 0 is the control unit; requester 1 is the secondary master (I/O / loader).
- Serialises single-word read/write transactions, drives the memory interface's command/address/write-data, waits the memory latency, returns read data, and pulses completion to the served requester.
- Round-robin between requesters by default.

---
 rtl/mem_access_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter/sequencer for the shared data memory: grant+issue one cycle after request, done MEM_LAT+2 cycles after request.
// Round-robin on ties; define MEM_ARB_FIXED_PRIO_EN for fixed priority to requester 0. Losers stay pending until IDLE.
`timescale 1ns/1ps
module mem_access_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_cmd_q, mem_cmd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              win1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win1 = req1 & ~req0;
`else
    // last_q = 1 means requester 1 was served last, so requester 0 takes the next tie.
    logic last_q, last_d;
    assign win1 = req1 & (~req0 | ~last_q);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_cmd_d   = mem_cmd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    sel_d       = win1;
                    mem_cmd_d   = win1 ? we1 : we0;
                    mem_addr_d  = win1 ? addr1 : addr0;
                    mem_wdata_d = win1 ? wdata1 : wdata0;
                    gnt0_d      = ~win1;
                    gnt1_d      = win1;
                    mem_en_d    = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    if (!mem_cmd_q) begin
                        if (sel_q) rdata1_d = mem_rdata;
                        else       rdata0_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                last_d = sel_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            sel_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_cmd_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mem_en_q    <= mem_en_d;
            mem_cmd_q   <= mem_cmd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_cmd   = mem_cmd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench driving one arbiter with MEM_LAT=1 and one with MEM_LAT=3 from shared requester inputs.
`timescale 1ns/1ps
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;

    logic       gnt0_l1, done0_l1, gnt1_l1, done1_l1, mem_en_l1, mem_cmd_l1, busy_l1;
    logic [7:0] rdata0_l1, rdata1_l1, mem_addr_l1, mem_wdata_l1, mem_rdata_l1;
    logic       gnt0_l3, done0_l3, gnt1_l3, done1_l3, mem_en_l3, mem_cmd_l3, busy_l3;
    logic [7:0] rdata0_l3, rdata1_l3, mem_addr_l3, mem_wdata_l3, mem_rdata_l3;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;
    int done0_cnt = 0;
    int q_l1[$];
    int q_l3[$];
    int wr_cnt_l3;
    logic [15:0] wr_last_l3;

    always #5 clk = ~clk;

    mem_access_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_l1), .done0(done0_l1), .rdata0(rdata0_l1),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_l1), .done1(done1_l1), .rdata1(rdata1_l1),
        .mem_en(mem_en_l1), .mem_cmd(mem_cmd_l1), .mem_addr(mem_addr_l1),
        .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata_l1), .busy(busy_l1)
    );

    mem_access_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_l3), .done0(done0_l3), .rdata0(rdata0_l3),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_l3), .done1(done1_l3), .rdata1(rdata1_l3),
        .mem_en(mem_en_l3), .mem_cmd(mem_cmd_l3), .mem_addr(mem_addr_l3),
        .mem_wdata(mem_wdata_l3), .mem_rdata(mem_rdata_l3), .busy(busy_l3)
    );

    // Memory model: read data is a fixed function of the address (0x10 -> 0xA5).
    assign mem_rdata_l1 = mem_addr_l1 ^ 8'hB5;
    assign mem_rdata_l3 = mem_addr_l3 ^ 8'hB5;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_l3  <= 0;
            wr_last_l3 <= '0;
        end else if (mem_en_l3 && mem_cmd_l3) begin
            wr_cnt_l3  <= wr_cnt_l3 + 1;
            wr_last_l3 <= {mem_addr_l3, mem_wdata_l3};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0_l1 && gnt1_l1) viol++;
            if (gnt0_l3 && gnt1_l3) viol++;
            if (done0_l1 && done1_l1) viol++;
            if (done0_l3 && done1_l3) viol++;
            if (mem_en_l1 != (gnt0_l1 | gnt1_l1)) viol++;
            if (mem_en_l3 != (gnt0_l3 | gnt1_l3)) viol++;
            if (gnt0_l1) q_l1.push_back(0);
            if (gnt1_l1) q_l1.push_back(1);
            if (gnt0_l3) q_l3.push_back(0);
            if (gnt1_l3) q_l3.push_back(1);
            if (done0_l1 || done0_l3) done0_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s3, d0;
        int exp_ord[4];
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        tick();
        tick();
        check_eq("rst_busy", busy_l1, 0);
        check_eq("rst_gnt0", gnt0_l1, 0);
        check_eq("rst_mem_en", mem_en_l1, 0);
        check_eq("rst_mem_addr", mem_addr_l1, 0);
        check_eq("rst_rdata0", rdata0_l1, 0);
        check_eq("rst_done0_l3", done0_l3, 0);
        rst = 1'b0;

        // Single read, MEM_LAT=1
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        check_eq("rd_gnt0", gnt0_l1, 1);
        check_eq("rd_gnt1", gnt1_l1, 0);
        check_eq("rd_mem_en", mem_en_l1, 1);
        check_eq("rd_mem_cmd", mem_cmd_l1, 0);
        check_eq("rd_mem_addr", mem_addr_l1, 8'h10);
        check_eq("rd_busy", busy_l1, 1);
        req0 = 0;
        tick();
        check_eq("rd_c2_mem_en", mem_en_l1, 0);
        check_eq("rd_c2_gnt0", gnt0_l1, 0);
        check_eq("rd_c2_done0", done0_l1, 0);
        tick();
        check_eq("rd_c3_done0", done0_l1, 1);
        check_eq("rd_c3_rdata0", rdata0_l1, 8'hA5);
        check_eq("rd_c3_rdata1", rdata1_l1, 0);
        tick();
        check_eq("rd_c4_done0", done0_l1, 0);
        check_eq("rd_c4_busy", busy_l1, 0);
        tick();
        check_eq("rd_l3_done0", done0_l3, 1);
        check_eq("rd_l3_rdata0", rdata0_l3, 8'hA5);
        tick();

        // Single write, MEM_LAT=3
        do_reset();
        req1 = 1; we1 = 1; addr1 = 8'h3C; wdata1 = 8'h5A;
        tick();
        check_eq("wr_gnt1", gnt1_l3, 1);
        check_eq("wr_mem_en", mem_en_l3, 1);
        check_eq("wr_mem_cmd", mem_cmd_l3, 1);
        check_eq("wr_mem_wdata", mem_wdata_l3, 8'h5A);
        check_eq("wr_mem_addr", mem_addr_l3, 8'h3C);
        req1 = 0; we1 = 0;
        tick();
        check_eq("wr_c2_mem_en", mem_en_l3, 0);
        check_eq("wr_c2_wdata_hold", mem_wdata_l3, 8'h5A);
        tick();
        tick();
        check_eq("wr_c4_done1", done1_l3, 0);
        tick();
        check_eq("wr_c5_done1", done1_l3, 1);
        check_eq("wr_c5_rdata1", rdata1_l3, 0);
        check_eq("wr_count", wr_cnt_l3, 1);
        check_eq("wr_mem_content", wr_last_l3, 16'h3C5A);
        tick();
        check_eq("wr_c6_done1", done1_l3, 0);

        // Operand change after grant
        do_reset();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        check_eq("op_gnt0", gnt0_l1, 1);
        req0 = 0;
        tick();
        addr0 = 8'hFF;
        check_eq("op_c2_addr", mem_addr_l1, 8'h10);
        tick();
        check_eq("op_c3_done0", done0_l1, 1);
        check_eq("op_c3_addr", mem_addr_l1, 8'h10);
        repeat (4) tick();

        // Simultaneous requests held high
        do_reset();
        s1 = q_l1.size();
        s3 = q_l3.size();
        req0 = 1; we0 = 0; addr0 = 8'h20;
        req1 = 1; we1 = 0; addr1 = 8'h21;
        for (int i = 0; i < 60 && (q_l1.size() < s1 + 4 || q_l3.size() < s3 + 4); i++) tick();
        req0 = 0; req1 = 0;
        check_eq("rr_budget", (q_l1.size() >= s1 + 4) && (q_l3.size() >= s3 + 4), 1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("order_l1_%0d", i), q_l1[s1 + i], exp_ord[i]);
            check_eq($sformatf("order_l3_%0d", i), q_l3[s3 + i], exp_ord[i]);
        end
        repeat (8) tick();
        check_eq("rr_idle_l1", busy_l1, 0);
        check_eq("rr_idle_l3", busy_l3, 0);

        // Reset during WAIT
        do_reset();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        req0 = 0;
        repeat (6) tick();
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h77;
        tick();
        req0 = 0; we0 = 0;
        tick();
        check_eq("mid_busy_before", busy_l3, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_busy_l1", busy_l1, 0);
        check_eq("mid_busy_l3", busy_l3, 0);
        check_eq("mid_mem_en_l3", mem_en_l3, 0);
        check_eq("mid_done0_l1", done0_l1, 0);
        check_eq("mid_done0_l3", done0_l3, 0);
        tick();
        rst = 1'b0;
        d0 = done0_cnt;
        repeat (6) tick();
        check_eq("mid_no_done", done0_cnt, d0);
        req0 = 1; addr0 = 8'h11; req1 = 1; addr1 = 8'h12;
        tick();
        check_eq("mid_tie_gnt0_l1", gnt0_l1, 1);
        check_eq("mid_tie_gnt1_l1", gnt1_l1, 0);
        check_eq("mid_tie_gnt0_l3", gnt0_l3, 1);
        check_eq("mid_tie_gnt1_l3", gnt1_l3, 0);
        req0 = 0; req1 = 0;
        repeat (8) tick();

        check_eq("protocol_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
